// File: rtl/iob_dma_write_axis2axi.sv
// AXI-Stream to AXI4 write converter: drains 32-bit stream words into INCR write
// bursts, splitting a transfer in two when it crosses a 4 KB boundary.
module iob_dma_write_axis2axi #(
   parameter int AXI_ADDR_W = 32,
   parameter int AXI_DATA_W = 32,
   parameter int AXI_LEN_W  = 8,
   parameter int AXI_ID_W   = 1
) (
   input  logic                    clk_i,
   input  logic                    arst_n_i,
   input  logic                    cke_i,
   input  logic [AXI_ADDR_W-1:0]   w_addr_i,
   input  logic [AXI_LEN_W:0]      w_length_i,
   input  logic                    w_start_transfer_i,
   output logic                    w_busy_o,
   output logic                    w_error_o,
   output logic [AXI_ID_W-1:0]     axi_awid_o,
   output logic [AXI_ADDR_W-1:0]   axi_awaddr_o,
   output logic [AXI_LEN_W-1:0]    axi_awlen_o,
   output logic [2:0]              axi_awsize_o,
   output logic [1:0]              axi_awburst_o,
   output logic [1:0]              axi_awlock_o,
   output logic [3:0]              axi_awcache_o,
   output logic [3:0]              axi_awqos_o,
   output logic                    axi_awvalid_o,
   input  logic                    axi_awready_i,
   output logic [AXI_DATA_W-1:0]   axi_wdata_o,
   output logic [AXI_DATA_W/8-1:0] axi_wstrb_o,
   output logic                    axi_wlast_o,
   output logic                    axi_wvalid_o,
   input  logic                    axi_wready_i,
   input  logic [AXI_ID_W-1:0]     axi_bid_i,
   input  logic [1:0]              axi_bresp_i,
   input  logic                    axi_bvalid_i,
   output logic                    axi_bready_o,
   input  logic [AXI_DATA_W-1:0]   axis_in_data_i,
   input  logic                    axis_in_valid_i,
   output logic                    axis_in_ready_o
);

   localparam int CW = (AXI_LEN_W + 1 > 11) ? AXI_LEN_W + 1 : 11;
   localparam logic [AXI_LEN_W:0]   ONE_L = 1;
   localparam logic [AXI_LEN_W-1:0] ONE_B = 1;

   typedef enum logic [1:0] {WAIT_START, START_BURST, TRANSF_DATA, WAIT_BRESP} state_t;

   state_t                  state, state_nxt;
   logic [AXI_ADDR_W-1:0]   awaddr;
   logic [AXI_LEN_W-1:0]    awlen;
   logic [AXI_LEN_W-1:0]    beat_cnt;
   logic [AXI_LEN_W:0]      remaining;
   logic                    awvalid;
   logic                    error;

   logic                    start_ok, in_data, aw_hs, w_hs, b_hs;
   logic [10:0]             room;
   logic [CW-1:0]           room_ext, len_ext, first;
   logic [AXI_LEN_W:0]      first_len, awlen_p1;
   logic                    unused_bid;

   assign unused_bid = ^axi_bid_i;

   assign in_data  = (state == TRANSF_DATA);
   assign start_ok = (state == WAIT_START) & w_start_transfer_i & (w_length_i != '0);
   assign aw_hs    = awvalid & axi_awready_i;
   assign w_hs     = axis_in_valid_i & axi_wready_i & in_data;
   assign b_hs     = axi_bvalid_i & (state == WAIT_BRESP);

   // Words left before the next 4 KB page: start address is word aligned, so count in words.
   assign room      = 11'd1024 - {1'b0, w_addr_i[11:2]};
   assign room_ext  = CW'(room);
   assign len_ext   = CW'(w_length_i);
   assign first     = (len_ext < room_ext) ? len_ext : room_ext;
   assign first_len = first[AXI_LEN_W:0];
   assign awlen_p1  = {1'b0, awlen} + ONE_L;

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state <= WAIT_START;
      end else if (cke_i) begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         WAIT_START:  if (start_ok) state_nxt = START_BURST;
         START_BURST: if (axi_awready_i) state_nxt = TRANSF_DATA;
         TRANSF_DATA: if (w_hs & axi_wlast_o) state_nxt = WAIT_BRESP;
         WAIT_BRESP:  if (axi_bvalid_i) state_nxt = (remaining != '0) ? START_BURST : WAIT_START;
         default:     state_nxt = WAIT_START;
      endcase
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         awaddr    <= '0;
         awlen     <= '0;
         remaining <= '0;
         awvalid   <= 1'b0;
         error     <= 1'b0;
         beat_cnt  <= '0;
      end else if (cke_i) begin
         if (start_ok) begin
            awaddr    <= w_addr_i;
            awlen     <= AXI_LEN_W'(first_len - ONE_L);
            remaining <= w_length_i - first_len;
            awvalid   <= 1'b1;
            error     <= 1'b0;
         end else if (b_hs) begin
            if (axi_bresp_i != 2'b00) error <= 1'b1;
            // Second half of a page-split transfer starts right where the first ended.
            if (remaining != '0) begin
               awaddr    <= awaddr + AXI_ADDR_W'({awlen_p1, 2'b00});
               awlen     <= AXI_LEN_W'(remaining - ONE_L);
               remaining <= '0;
               awvalid   <= 1'b1;
            end
         end
         if (aw_hs) begin
            awvalid  <= 1'b0;
            beat_cnt <= '0;
         end else if (w_hs) begin
            beat_cnt <= beat_cnt + ONE_B;
         end
      end
   end

   assign w_busy_o        = (state != WAIT_START);
   assign w_error_o       = error;

   assign axi_awid_o      = '0;
   assign axi_awaddr_o    = awaddr;
   assign axi_awlen_o     = awlen;
   assign axi_awsize_o    = 3'd2;
   assign axi_awburst_o   = 2'd1;
   assign axi_awlock_o    = 2'd0;
   assign axi_awcache_o   = 4'd2;
   assign axi_awqos_o     = 4'd0;
   assign axi_awvalid_o   = awvalid;

   assign axi_wdata_o     = axis_in_data_i;
   assign axi_wstrb_o     = '1;
   assign axi_wvalid_o    = axis_in_valid_i & in_data;
   assign axi_wlast_o     = in_data & (beat_cnt == awlen);
   assign axis_in_ready_o = axi_wready_i & in_data;

   assign axi_bready_o    = (state == WAIT_BRESP);

endmodule

// File: tb/tb_iob_dma_write_axis2axi.sv
// Directed bench for iob_dma_write_axis2axi: drives stream/AXI responder per cycle
// and checks recorded AW/W/B traffic against hand-computed expectations.
module tb_iob_dma_write_axis2axi;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int LW = 8;
   localparam int IW = 1;

   logic          clk = 1'b0;
   logic          arst_n_i = 1'b0;
   logic          cke_i = 1'b1;
   logic [AW-1:0] w_addr_i = '0;
   logic [LW:0]   w_length_i = '0;
   logic          w_start_transfer_i = 1'b0;
   logic          w_busy_o, w_error_o;
   logic [IW-1:0] axi_awid_o;
   logic [AW-1:0] axi_awaddr_o;
   logic [LW-1:0] axi_awlen_o;
   logic [2:0]    axi_awsize_o;
   logic [1:0]    axi_awburst_o, axi_awlock_o;
   logic [3:0]    axi_awcache_o, axi_awqos_o;
   logic          axi_awvalid_o;
   logic          axi_awready_i = 1'b0;
   logic [DW-1:0] axi_wdata_o;
   logic [3:0]    axi_wstrb_o;
   logic          axi_wlast_o, axi_wvalid_o;
   logic          axi_wready_i = 1'b0;
   logic [IW-1:0] axi_bid_i = '0;
   logic [1:0]    axi_bresp_i = 2'b00;
   logic          axi_bvalid_i = 1'b0;
   logic          axi_bready_o;
   logic [DW-1:0] axis_in_data_i = '0;
   logic          axis_in_valid_i = 1'b0;
   logic          axis_in_ready_o;

   int tests = 0;
   int fails = 0;

   iob_dma_write_axis2axi #(.AXI_ADDR_W(AW), .AXI_DATA_W(DW), .AXI_LEN_W(LW), .AXI_ID_W(IW)) dut (
      .clk_i(clk), .arst_n_i(arst_n_i), .cke_i(cke_i),
      .w_addr_i(w_addr_i), .w_length_i(w_length_i), .w_start_transfer_i(w_start_transfer_i),
      .w_busy_o(w_busy_o), .w_error_o(w_error_o),
      .axi_awid_o(axi_awid_o), .axi_awaddr_o(axi_awaddr_o), .axi_awlen_o(axi_awlen_o),
      .axi_awsize_o(axi_awsize_o), .axi_awburst_o(axi_awburst_o), .axi_awlock_o(axi_awlock_o),
      .axi_awcache_o(axi_awcache_o), .axi_awqos_o(axi_awqos_o), .axi_awvalid_o(axi_awvalid_o),
      .axi_awready_i(axi_awready_i),
      .axi_wdata_o(axi_wdata_o), .axi_wstrb_o(axi_wstrb_o), .axi_wlast_o(axi_wlast_o),
      .axi_wvalid_o(axi_wvalid_o), .axi_wready_i(axi_wready_i),
      .axi_bid_i(axi_bid_i), .axi_bresp_i(axi_bresp_i), .axi_bvalid_i(axi_bvalid_i),
      .axi_bready_o(axi_bready_o),
      .axis_in_data_i(axis_in_data_i), .axis_in_valid_i(axis_in_valid_i),
      .axis_in_ready_o(axis_in_ready_o)
   );

   always #5 clk = ~clk;

   // Traffic recorded by run_xfer
   logic [31:0] aw_addr_q[$];
   int          aw_len_q[$];
   logic [31:0] wd_q[$];
   int          wlast_q[$];
   int          b_cnt, sh_cnt;
   bit          tmo;
   logic        busy_first, awv_first, err_first, busy_after_b, awv_after_b, err_at_aw2;

   task automatic idle_inputs();
      w_start_transfer_i = 1'b0;
      axi_awready_i = 1'b0;
      axi_wready_i = 1'b0;
      axis_in_valid_i = 1'b0;
      axi_bvalid_i = 1'b0;
      axi_bresp_i = 2'b00;
   endtask

   // mode 0: always ready/valid; mode 1: awready delayed, wready 1010..., stream valid gapped
   task automatic run_xfer(input logic [31:0] addr, input int len, input int mode,
                           input logic [1:0] bresp0, input bit busy_start, input logic [31:0] base);
      int widx, last_b;
      bit bpend, done;
      aw_addr_q.delete(); aw_len_q.delete(); wd_q.delete(); wlast_q.delete();
      b_cnt = 0; sh_cnt = 0; tmo = 0; widx = 0; last_b = -10; bpend = 0; done = 0;
      busy_after_b = 1'bx; awv_after_b = 1'bx; err_at_aw2 = 1'bx;
      @(negedge clk);
      w_addr_i = addr; w_length_i = (LW+1)'(len); w_start_transfer_i = 1'b1;
      @(negedge clk);
      for (int cyc = 0; cyc < 800 && !done; cyc++) begin
         w_start_transfer_i = busy_start && (cyc == 3);
         if (busy_start && cyc == 3) begin
            w_addr_i = 32'h800; w_length_i = 9'd5;
         end
         axi_awready_i   = (mode == 1) ? (cyc % 2 == 1) : 1'b1;
         axi_wready_i    = (mode == 1) ? (cyc % 2 == 0) : 1'b1;
         axis_in_valid_i = (mode == 1) ? (cyc % 3 != 1) : 1'b1;
         axis_in_data_i  = base + 32'(widx);
         axi_bvalid_i    = bpend;
         axi_bresp_i     = (b_cnt == 0) ? bresp0 : 2'b00;
         #1;
         if (cyc == 0) begin
            busy_first = w_busy_o; awv_first = axi_awvalid_o; err_first = w_error_o;
         end
         if (cyc == last_b + 1) begin
            busy_after_b = w_busy_o;
            if (b_cnt == 1) awv_after_b = axi_awvalid_o;
         end
         if (axi_awvalid_o && axi_awready_i) begin
            aw_addr_q.push_back(axi_awaddr_o);
            aw_len_q.push_back(int'(axi_awlen_o));
            if (aw_addr_q.size() == 2) err_at_aw2 = w_error_o;
         end
         if (axis_in_valid_i && axis_in_ready_o) sh_cnt++;
         if (axi_bvalid_i && axi_bready_o) begin
            b_cnt++; bpend = 0; last_b = cyc;
         end
         if (axi_wvalid_o && axi_wready_i) begin
            wd_q.push_back(axi_wdata_o);
            if (axi_wlast_o) begin
               wlast_q.push_back(widx); bpend = 1;
            end
            widx++;
         end
         if (cyc > last_b && b_cnt > 0 && !w_busy_o) done = 1;
         @(negedge clk);
      end
      if (!done) tmo = 1;
      idle_inputs();
   endtask

   task automatic test_reset();
      axis_in_valid_i = 1'b1; axi_wready_i = 1'b1;
      #12;
      tests++; if ({w_busy_o, axi_awvalid_o, axi_wvalid_o, axi_wlast_o, axi_bready_o, axis_in_ready_o} !== 6'b0) begin
         fails++; $display("FAIL reset_ctrl: got %b want 000000", {w_busy_o, axi_awvalid_o, axi_wvalid_o, axi_wlast_o, axi_bready_o, axis_in_ready_o}); end
      tests++; if ({axi_awaddr_o, axi_awlen_o, w_error_o} !== '0) begin
         fails++; $display("FAIL reset_regs: awaddr=%h awlen=%0d err=%b want 0", axi_awaddr_o, axi_awlen_o, w_error_o); end
      tests++; if ({axi_awsize_o, axi_awburst_o, axi_awcache_o, axi_wstrb_o} !== {3'd2, 2'd1, 4'd2, 4'hF}) begin
         fails++; $display("FAIL constants: size=%0d burst=%0d cache=%0d strb=%h", axi_awsize_o, axi_awburst_o, axi_awcache_o, axi_wstrb_o); end
      @(negedge clk);
      arst_n_i = 1'b1;
      idle_inputs();
   endtask

   task automatic test_single_burst();
      bit bad;
      run_xfer(32'h100, 16, 0, 2'b00, 0, 32'hA000_0000);
      tests++; if (tmo !== 1'b0) begin fails++; $display("FAIL single_timeout: got %b want 0", tmo); end
      tests++; if ({busy_first, awv_first} !== 2'b11) begin
         fails++; $display("FAIL single_start_latency: busy=%b awvalid=%b want 1 1", busy_first, awv_first); end
      tests++; if (aw_addr_q.size() != 1 || aw_addr_q[0] !== 32'h100 || aw_len_q[0] != 15) begin
         fails++; $display("FAIL single_aw: n=%0d addr=%h len=%0d want 1 100 15", aw_addr_q.size(), aw_addr_q[0], aw_len_q[0]); end
      bad = (wd_q.size() != 16);
      foreach (wd_q[i]) if (wd_q[i] !== 32'hA000_0000 + 32'(i)) bad = 1;
      tests++; if (bad) begin fails++; $display("FAIL single_data: got %0d beats, want 16 in order", wd_q.size()); end
      tests++; if (wlast_q.size() != 1 || wlast_q[0] != 15) begin
         fails++; $display("FAIL single_wlast: n=%0d idx=%0d want 1 15", wlast_q.size(), wlast_q[0]); end
      tests++; if (b_cnt != 1 || busy_after_b !== 1'b0) begin
         fails++; $display("FAIL single_b: b=%0d busy_after=%b want 1 0", b_cnt, busy_after_b); end
   endtask

   task automatic test_4k_split();
      bit bad;
      run_xfer(32'hFF0, 8, 0, 2'b00, 0, 32'hB000_0000);
      tests++; if (tmo !== 1'b0 || aw_addr_q.size() != 2) begin
         fails++; $display("FAIL split_aw_count: tmo=%b n=%0d want 0 2", tmo, aw_addr_q.size()); end
      tests++; if (aw_addr_q[0] !== 32'hFF0 || aw_len_q[0] != 3 || aw_addr_q[1] !== 32'h1000 || aw_len_q[1] != 3) begin
         fails++; $display("FAIL split_aw: %h/%0d %h/%0d want ff0/3 1000/3", aw_addr_q[0], aw_len_q[0], aw_addr_q[1], aw_len_q[1]); end
      tests++; if (awv_after_b !== 1'b1) begin fails++; $display("FAIL split_aw_after_b: got %b want 1", awv_after_b); end
      bad = (wd_q.size() != 8);
      foreach (wd_q[i]) if (wd_q[i] !== 32'hB000_0000 + 32'(i)) bad = 1;
      tests++; if (bad) begin fails++; $display("FAIL split_data: got %0d beats, want 8 in order", wd_q.size()); end
      tests++; if (wlast_q.size() != 2 || wlast_q[0] != 3 || wlast_q[1] != 7 || b_cnt != 2) begin
         fails++; $display("FAIL split_wlast: n=%0d b=%0d want wlast at 3,7 and 2 B", wlast_q.size(), b_cnt); end
   endtask

   task automatic test_backpressure();
      bit bad;
      run_xfer(32'h0, 4, 1, 2'b00, 0, 32'hC000_0000);
      tests++; if (tmo !== 1'b0 || aw_addr_q.size() != 1 || aw_len_q[0] != 3) begin
         fails++; $display("FAIL bp_aw: tmo=%b n=%0d len=%0d want 0 1 3", tmo, aw_addr_q.size(), aw_len_q[0]); end
      tests++; if (sh_cnt != 4) begin fails++; $display("FAIL bp_stream_hs: got %0d want 4", sh_cnt); end
      bad = (wd_q.size() != 4);
      foreach (wd_q[i]) if (wd_q[i] !== 32'hC000_0000 + 32'(i)) bad = 1;
      tests++; if (bad) begin fails++; $display("FAIL bp_data: got %0d beats, want 4 in order", wd_q.size()); end
      tests++; if (wlast_q.size() != 1 || wlast_q[0] != 3) begin
         fails++; $display("FAIL bp_wlast: n=%0d idx=%0d want 1 3", wlast_q.size(), wlast_q[0]); end
   endtask

   task automatic test_error();
      run_xfer(32'hFF8, 4, 0, 2'b10, 0, 32'hD000_0000);
      tests++; if (tmo !== 1'b0 || aw_addr_q.size() != 2 || aw_addr_q[1] !== 32'h1000 || aw_len_q[0] != 1 || aw_len_q[1] != 1) begin
         fails++; $display("FAIL err_split: n=%0d addr1=%h lens=%0d,%0d want 2 1000 1,1", aw_addr_q.size(), aw_addr_q[1], aw_len_q[0], aw_len_q[1]); end
      tests++; if (err_at_aw2 !== 1'b1) begin fails++; $display("FAIL err_during_2nd: got %b want 1", err_at_aw2); end
      tests++; if (w_error_o !== 1'b1) begin fails++; $display("FAIL err_sticky: got %b want 1", w_error_o); end
   endtask

   task automatic test_len0();
      @(negedge clk);
      w_addr_i = 32'h40; w_length_i = '0; w_start_transfer_i = 1'b1;
      @(negedge clk);
      w_start_transfer_i = 1'b0;
      #1;
      tests++; if ({w_busy_o, axi_awvalid_o} !== 2'b00) begin
         fails++; $display("FAIL len0_idle: busy=%b awvalid=%b want 0 0", w_busy_o, axi_awvalid_o); end
      tests++; if (w_error_o !== 1'b1) begin fails++; $display("FAIL len0_err_kept: got %b want 1", w_error_o); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_len256();
      bit bad;
      run_xfer(32'h0, 256, 0, 2'b00, 0, 32'hE000_0000);
      tests++; if (err_first !== 1'b0) begin fails++; $display("FAIL err_cleared: got %b want 0", err_first); end
      tests++; if (tmo !== 1'b0 || aw_addr_q.size() != 1 || aw_len_q[0] != 255) begin
         fails++; $display("FAIL len256_aw: tmo=%b n=%0d len=%0d want 0 1 255", tmo, aw_addr_q.size(), aw_len_q[0]); end
      bad = (wd_q.size() != 256);
      foreach (wd_q[i]) if (wd_q[i] !== 32'hE000_0000 + 32'(i)) bad = 1;
      tests++; if (bad || wlast_q.size() != 1 || wlast_q[0] != 255) begin
         fails++; $display("FAIL len256_data: beats=%0d wlast_n=%0d want 256 1", wd_q.size(), wlast_q.size()); end
   endtask

   task automatic test_busy_start();
      run_xfer(32'h300, 4, 0, 2'b00, 1, 32'hF000_0000);
      tests++; if (tmo !== 1'b0 || aw_addr_q.size() != 1 || aw_addr_q[0] !== 32'h300 || aw_len_q[0] != 3) begin
         fails++; $display("FAIL busy_start_aw: n=%0d addr=%h len=%0d want 1 300 3", aw_addr_q.size(), aw_addr_q[0], aw_len_q[0]); end
      tests++; if (wd_q.size() != 4 || axi_awvalid_o !== 1'b0) begin
         fails++; $display("FAIL busy_start_beats: beats=%0d awvalid=%b want 4 0", wd_q.size(), axi_awvalid_o); end
   endtask

   task automatic test_reset_mid();
      int beats = 0;
      @(negedge clk);
      w_addr_i = 32'h200; w_length_i = 9'd8; w_start_transfer_i = 1'b1;
      axi_awready_i = 1'b1; axi_wready_i = 1'b1; axis_in_valid_i = 1'b1;
      @(negedge clk);
      w_start_transfer_i = 1'b0;
      for (int i = 0; i < 20 && beats < 2; i++) begin
         axis_in_data_i = 32'(beats);
         #1;
         if (axi_wvalid_o && axi_wready_i) beats++;
         @(negedge clk);
      end
      arst_n_i = 1'b0;
      #1;
      tests++; if (beats != 2 || {w_busy_o, axi_awvalid_o, axi_wvalid_o, axi_wlast_o, axi_bready_o, axis_in_ready_o} !== 6'b0) begin
         fails++; $display("FAIL rst_mid_ctrl: beats=%0d flags=%b want 2 000000", beats,
                           {w_busy_o, axi_awvalid_o, axi_wvalid_o, axi_wlast_o, axi_bready_o, axis_in_ready_o}); end
      tests++; if ({axi_awaddr_o, axi_awlen_o, w_error_o} !== '0) begin
         fails++; $display("FAIL rst_mid_regs: awaddr=%h awlen=%0d err=%b want 0", axi_awaddr_o, axi_awlen_o, w_error_o); end
      @(negedge clk);
      arst_n_i = 1'b1;
      idle_inputs();
      run_xfer(32'h40, 2, 0, 2'b00, 0, 32'h1234_0000);
      tests++; if (tmo !== 1'b0 || aw_addr_q.size() != 1 || aw_addr_q[0] !== 32'h40 || aw_len_q[0] != 1) begin
         fails++; $display("FAIL rst_mid_restart_aw: n=%0d addr=%h len=%0d want 1 40 1", aw_addr_q.size(), aw_addr_q[0], aw_len_q[0]); end
      tests++; if (wd_q.size() != 2 || wd_q[1] !== 32'h1234_0001 || wlast_q.size() != 1 || wlast_q[0] != 1 || b_cnt != 1) begin
         fails++; $display("FAIL rst_mid_restart_w: beats=%0d wlast_n=%0d b=%0d want 2 1 1", wd_q.size(), wlast_q.size(), b_cnt); end
   endtask

   initial begin
      test_reset();
      test_single_burst();
      test_4k_split();
      test_backpressure();
      test_error();
      test_len0();
      test_len256();
      test_busy_start();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
